multi_commit_rob: RTL and testbench
===================================

MULTI_COMMIT_ROB -- requirements
Module: multi_commit_rob

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3; depth N = 2^RoB_WIDTH entries.
REQ-002 SHALL have parameter DUAL_COMMIT, default 1; 1 = up to two retirements per cycle, 0 = one.
REQ-003 SHALL use one clock, clk_in; reset is synchronous and active-high, rst_in.
REQ-004 clk_in  in  1  clock.
REQ-005 rst_in  in  1  synchronous active-high reset.
REQ-006 rdy_in  in  1  global enable; low = hold all state, outputs unchanged.
REQ-007 disp_en  in  1  allocate entry at tail.
REQ-008 disp_type  in  2  0 REGISTER, 1 BRANCH, 2 JALR, 3 STORE.
REQ-009 disp_rd, disp_pred, disp_ready  in  5/1/1  dest reg; predicted taken; already complete.
REQ-010 disp_pc, disp_alt_pc, disp_data  in  32 each  pc; mispredict redirect target; value if disp_ready.
REQ-011 cdb_en, cdb_idx, cdb_data  in  1/RoB_WIDTH/32  result broadcast.
REQ-012 qN_idx  in  RoB_WIDTH, N=0,1  operand lookup index.
REQ-013 qN_ready, qN_data  out  1/32, N=0,1  combinational lookup result.
REQ-014 rf_en  out  2  per-slot register-file write strobe (bit0 = older).
REQ-015 rf_reg, rf_idx, rf_data  out  10/2*RoB_WIDTH/64  packed per slot, slot0 in LSBs.
REQ-016 redirect_en, redirect_pc  out  1/32  fetch redirect (mispredict or jalr).
REQ-017 bp_en, bp_pc, bp_taken  out  1/32/1  predictor training.
REQ-018 full, tail_idx, count, flush_signal  out  1/RoB_WIDTH/RoB_WIDTH+1/1.

Function
REQ-019 SHALL track occupancy with count: full = (count == N); empty = (count == 0); head/tail wrap modulo N.
REQ-020 Allocation when disp_en && !full: write fields at tail, ready = disp_ready, tail+1; disp_en while full SHALL be ignored.
REQ-021 cdb_en SHALL set ready and data of cdb_idx at clock edge; CDB to a non-busy entry SHALL be ignored.
REQ-022 qN_ready/qN_data SHALL reflect entry state, bypassing cdb_en with matching cdb_idx in the same cycle.
REQ-023 Slot0 retires head when busy and ready; slot1 retires head+1 only if DUAL_COMMIT, slot0 retires, head+1 busy and ready, and both types are REGISTER or STORE.
REQ-024 REGISTER: rf_en bit set, rf_reg = rd, rf_idx = entry index, rf_data = data; STORE: no RF write.
REQ-025 BRANCH (slot0 only): bp_en=1, bp_pc=pc, bp_taken=data[0]; if data[0] != pred: redirect_en=1, redirect_pc=alt_pc, flush_signal=1.
REQ-026 JALR (slot0 only): RF write of pc+4 to rd, redirect_en=1, redirect_pc = data & ~1, flush_signal=1.
REQ-027 All strobe outputs SHALL be registered, one cycle after the retire decision, and pulse for exactly one cycle.
REQ-028 Cycle with flush_signal=1: clear all entries, head=tail=count=0, ignore disp_en and cdb_en, no retirement.
REQ-029 count next = count + alloc - retired (0..2); simultaneous allocate and retire when full SHALL be refused (full checked on current count).
REQ-030 An entry allocated with disp_ready=1 SHALL not retire in its allocation cycle.

Reset
REQ-031 rst_in SHALL clear all entries, head=tail=count=0, every output strobe 0, redirect_pc/bp_pc/rf_data 0; rst_in has priority over rdy_in and flush.

Verification
REQ-032 Fill 8 REGISTER entries (RoB_WIDTH=3) without CDB -> full=1, count=8; 9th disp_en ignored, tail_idx=0.
REQ-033 Two ready REGISTER at head (rd 5=0x11, rd 6=0x22), DUAL_COMMIT=1 -> rf_en=2'b11 next cycle, count drops by 2.
REQ-034 Head BRANCH pred=1, CDB data=0, alt_pc=0x100 -> redirect_en=1, redirect_pc=0x100, bp_taken=0, next cycle flush empties, count=0.
REQ-035 Head JALR pc=0x40 rd=1, CDB data=0x205 -> rf_data slot0=0x44, redirect_pc=0x204, flush_signal=1.
REQ-036 q0_idx=2 with cdb_en idx 2 data 0xABCD same cycle -> q0_ready=1, q0_data=0xABCD combinationally.
REQ-037 Wrap test: 20 alloc/retire cycles at steady count 3 -> head/tail wrap, retirement order equals allocation order.

Source files
------------

// File: rtl/multi_commit_rob.sv
`default_nettype none
// ============================================================================
// Module      : multi_commit_rob
// Description : Reorder buffer with in-order retirement of up to two entries
//               per cycle, branch/JALR resolution and registered strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_commit_rob #(
    parameter int RoB_WIDTH   = 3,
    parameter int DUAL_COMMIT = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     disp_en,
    input  logic [1:0]               disp_type,
    input  logic [4:0]               disp_rd,
    input  logic                     disp_pred,
    input  logic                     disp_ready,
    input  logic [31:0]              disp_pc,
    input  logic [31:0]              disp_alt_pc,
    input  logic [31:0]              disp_data,
    input  logic                     cdb_en,
    input  logic [RoB_WIDTH-1:0]     cdb_idx,
    input  logic [31:0]              cdb_data,
    input  logic [RoB_WIDTH-1:0]     q0_idx,
    input  logic [RoB_WIDTH-1:0]     q1_idx,
    output logic                     q0_ready,
    output logic [31:0]              q0_data,
    output logic                     q1_ready,
    output logic [31:0]              q1_data,
    output logic [1:0]               rf_en,
    output logic [9:0]               rf_reg,
    output logic [2*RoB_WIDTH-1:0]   rf_idx,
    output logic [63:0]              rf_data,
    output logic                     redirect_en,
    output logic [31:0]              redirect_pc,
    output logic                     bp_en,
    output logic [31:0]              bp_pc,
    output logic                     bp_taken,
    output logic                     full,
    output logic [RoB_WIDTH-1:0]     tail_idx,
    output logic [RoB_WIDTH:0]       count,
    output logic                     flush_signal
);
    localparam int         c_DEPTH  = 1 << RoB_WIDTH;
    localparam logic [1:0] c_T_REG  = 2'd0;
    localparam logic [1:0] c_T_BR   = 2'd1;
    localparam logic [1:0] c_T_JALR = 2'd2;
    localparam logic [1:0] c_T_ST   = 2'd3;

    logic [c_DEPTH-1:0]     busy_q, ready_q, pred_q;
    logic [1:0]             type_q [c_DEPTH];
    logic [4:0]             rd_q   [c_DEPTH];
    logic [31:0]            pc_q   [c_DEPTH];
    logic [31:0]            alt_q  [c_DEPTH];
    logic [31:0]            data_q [c_DEPTH];

    logic [RoB_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [RoB_WIDTH:0]     count_q, count_d;

    logic [1:0]             rf_en_q, rf_en_d;
    logic [9:0]             rf_reg_q, rf_reg_d;
    logic [2*RoB_WIDTH-1:0] rf_idx_q, rf_idx_d;
    logic [63:0]            rf_data_q, rf_data_d;
    logic                   redirect_en_q, redirect_en_d;
    logic [31:0]            redirect_pc_q, redirect_pc_d;
    logic                   bp_en_q, bp_en_d, bp_taken_q, bp_taken_d;
    logic [31:0]            bp_pc_q, bp_pc_d;
    logic                   flush_q, flush_d;

    logic                   w_full, w_alloc, w_cdb, w_ret0, w_ret1;
    logic                   w_simple0, w_simple1;
    logic [RoB_WIDTH-1:0]   w_h1;
    logic [1:0]             w_t0, w_t1, w_nret;

    assign w_full    = (count_q == (RoB_WIDTH+1)'(c_DEPTH));
    assign w_alloc   = disp_en && !w_full && !flush_q;
    assign w_cdb     = cdb_en && busy_q[cdb_idx] && !flush_q;
    assign w_h1      = head_q + RoB_WIDTH'(1);
    assign w_t0      = type_q[head_q];
    assign w_t1      = type_q[w_h1];
    assign w_simple0 = (w_t0 == c_T_REG) || (w_t0 == c_T_ST);
    assign w_simple1 = (w_t1 == c_T_REG) || (w_t1 == c_T_ST);
    assign w_ret0    = !flush_q && busy_q[head_q] && ready_q[head_q];
    // Control-flow entries retire alone so a redirect never trails a younger commit.
    assign w_ret1    = (DUAL_COMMIT != 0) && w_ret0 && busy_q[w_h1] && ready_q[w_h1]
                       && w_simple0 && w_simple1;
    assign w_nret    = {1'b0, w_ret0} + {1'b0, w_ret1};

    always_comb begin
        rf_en_d       = '0;
        rf_reg_d      = '0;
        rf_idx_d      = '0;
        rf_data_d     = '0;
        redirect_en_d = 1'b0;
        redirect_pc_d = '0;
        bp_en_d       = 1'b0;
        bp_pc_d       = '0;
        bp_taken_d    = 1'b0;
        flush_d       = 1'b0;
        if (w_ret0) begin
            case (w_t0)
                c_T_REG: begin
                    rf_en_d[0]                = 1'b1;
                    rf_reg_d[4:0]             = rd_q[head_q];
                    rf_idx_d[RoB_WIDTH-1:0]   = head_q;
                    rf_data_d[31:0]           = data_q[head_q];
                end
                c_T_BR: begin
                    bp_en_d    = 1'b1;
                    bp_pc_d    = pc_q[head_q];
                    bp_taken_d = data_q[head_q][0];
                    if (data_q[head_q][0] != pred_q[head_q]) begin
                        redirect_en_d = 1'b1;
                        redirect_pc_d = alt_q[head_q];
                        flush_d       = 1'b1;
                    end
                end
                c_T_JALR: begin
                    rf_en_d[0]              = 1'b1;
                    rf_reg_d[4:0]           = rd_q[head_q];
                    rf_idx_d[RoB_WIDTH-1:0] = head_q;
                    rf_data_d[31:0]         = pc_q[head_q] + 32'd4;
                    redirect_en_d           = 1'b1;
                    redirect_pc_d           = data_q[head_q] & 32'hFFFF_FFFE;
                    flush_d                 = 1'b1;
                end
                default: ;
            endcase
        end
        if (w_ret1 && (w_t1 == c_T_REG)) begin
            rf_en_d[1]                          = 1'b1;
            rf_reg_d[9:5]                       = rd_q[w_h1];
            rf_idx_d[2*RoB_WIDTH-1:RoB_WIDTH]   = w_h1;
            rf_data_d[63:32]                    = data_q[w_h1];
        end
    end

    always_comb begin
        head_d  = head_q + RoB_WIDTH'(w_nret);
        tail_d  = tail_q + RoB_WIDTH'(w_alloc);
        count_d = count_q + (RoB_WIDTH+1)'(w_alloc) - (RoB_WIDTH+1)'(w_nret);
        if (flush_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q        <= '0;
            ready_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            rf_en_q       <= '0;
            rf_reg_q      <= '0;
            rf_idx_q      <= '0;
            rf_data_q     <= '0;
            redirect_en_q <= 1'b0;
            redirect_pc_q <= '0;
            bp_en_q       <= 1'b0;
            bp_pc_q       <= '0;
            bp_taken_q    <= 1'b0;
            flush_q       <= 1'b0;
        end else if (rdy_in) begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            rf_en_q       <= rf_en_d;
            rf_reg_q      <= rf_reg_d;
            rf_idx_q      <= rf_idx_d;
            rf_data_q     <= rf_data_d;
            redirect_en_q <= redirect_en_d;
            redirect_pc_q <= redirect_pc_d;
            bp_en_q       <= bp_en_d;
            bp_pc_q       <= bp_pc_d;
            bp_taken_q    <= bp_taken_d;
            flush_q       <= flush_d;
            if (flush_q) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (w_ret0) busy_q[head_q] <= 1'b0;
                if (w_ret1) busy_q[w_h1]   <= 1'b0;
                if (w_cdb)  ready_q[cdb_idx] <= 1'b1;
                if (w_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= disp_ready;
                end
            end
        end
    end

    // Payload needs no reset: busy/ready gate every use of it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_q) begin
            if (w_cdb) data_q[cdb_idx] <= cdb_data;
            if (w_alloc) begin
                type_q[tail_q] <= disp_type;
                rd_q[tail_q]   <= disp_rd;
                pred_q[tail_q] <= disp_pred;
                pc_q[tail_q]   <= disp_pc;
                alt_q[tail_q]  <= disp_alt_pc;
                data_q[tail_q] <= disp_data;
            end
        end
    end

    assign q0_ready     = (cdb_en && cdb_idx == q0_idx) ? 1'b1     : ready_q[q0_idx];
    assign q0_data      = (cdb_en && cdb_idx == q0_idx) ? cdb_data : data_q[q0_idx];
    assign q1_ready     = (cdb_en && cdb_idx == q1_idx) ? 1'b1     : ready_q[q1_idx];
    assign q1_data      = (cdb_en && cdb_idx == q1_idx) ? cdb_data : data_q[q1_idx];

    assign rf_en        = rf_en_q;
    assign rf_reg       = rf_reg_q;
    assign rf_idx       = rf_idx_q;
    assign rf_data      = rf_data_q;
    assign redirect_en  = redirect_en_q;
    assign redirect_pc  = redirect_pc_q;
    assign bp_en        = bp_en_q;
    assign bp_pc        = bp_pc_q;
    assign bp_taken     = bp_taken_q;
    assign full         = w_full;
    assign tail_idx     = tail_q;
    assign count        = count_q;
    assign flush_signal = flush_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_commit_rob.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_commit_rob
// Description : Directed scoreboard bench for multi_commit_rob.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_commit_rob;
    localparam int W = 3;
    localparam logic [1:0] T_REG = 2'd0, T_BR = 2'd1, T_JALR = 2'd2;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, disp_en, disp_pred, disp_ready, cdb_en;
    logic [1:0]   disp_type;
    logic [4:0]   disp_rd;
    logic [31:0]  disp_pc, disp_alt_pc, disp_data, cdb_data;
    logic [W-1:0] cdb_idx, q0_idx, q1_idx;
    logic         q0_ready, q1_ready, redirect_en, bp_en, bp_taken, full, flush_signal;
    logic [31:0]  q0_data, q1_data, redirect_pc, bp_pc;
    logic [1:0]   rf_en;
    logic [9:0]   rf_reg;
    logic [2*W-1:0] rf_idx;
    logic [63:0]  rf_data;
    logic [W-1:0] tail_idx;
    logic [W:0]   count;

    multi_commit_rob #(.RoB_WIDTH(W), .DUAL_COMMIT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .disp_en(disp_en), .disp_type(disp_type), .disp_rd(disp_rd),
        .disp_pred(disp_pred), .disp_ready(disp_ready), .disp_pc(disp_pc),
        .disp_alt_pc(disp_alt_pc), .disp_data(disp_data),
        .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
        .q0_idx(q0_idx), .q1_idx(q1_idx),
        .q0_ready(q0_ready), .q0_data(q0_data), .q1_ready(q1_ready), .q1_data(q1_data),
        .rf_en(rf_en), .rf_reg(rf_reg), .rf_idx(rf_idx), .rf_data(rf_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .full(full), .tail_idx(tail_idx), .count(count), .flush_signal(flush_signal)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]   rd;
        logic [31:0]  data;
        logic [W-1:0] idx;
    } rf_exp_t;

    rf_exp_t      sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_tail;
    logic [W-1:0] ids [32];
    logic [W-1:0] id_a, id_b, id_x;
    logic [31:0]  v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_en = 1'b0;
        cdb_en  = 1'b0;
    endtask

    task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                        input logic rdy, input logic [31:0] pc, input logic [31:0] alt,
                        input logic [31:0] data, output logic [W-1:0] idx);
        disp_en = 1'b1; disp_type = t; disp_rd = rd; disp_pred = pred;
        disp_ready = rdy; disp_pc = pc; disp_alt_pc = alt; disp_data = data;
        idx    = m_tail;
        m_tail = m_tail + 1'b1;
    endtask

    task automatic cdb(input logic [W-1:0] idx, input logic [31:0] data);
        cdb_en = 1'b1; cdb_idx = idx; cdb_data = data;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [W-1:0] idx);
        rf_exp_t e;
        e.rd = rd; e.data = data; e.idx = idx;
        sb.push_back(e);
    endtask

    // Retirement monitor: every RF strobe must match the oldest expected write.
    always @(negedge clk_in) begin : mon
        rf_exp_t e;
        if (rst_in === 1'b0) begin
            for (int s = 0; s < 2; s++) begin
                if (rf_en[s] === 1'b1) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL rf_unexpected slot%0d observed_reg=%0d expected=none", s, rf_reg[5*s+:5]);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rf_reg",  64'(rf_reg[5*s+:5]),   64'(e.rd));
                        chk("rf_data", 64'(rf_data[32*s+:32]), 64'(e.data));
                        chk("rf_idx",  64'(rf_idx[W*s+:W]),   64'(e.idx));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; disp_en = 1'b0; disp_type = '0; disp_rd = '0;
        disp_pred = 1'b0; disp_ready = 1'b0; disp_pc = '0; disp_alt_pc = '0; disp_data = '0;
        cdb_en = 1'b0; cdb_idx = '0; cdb_data = '0; q0_idx = '0; q1_idx = '0;
        m_tail = '0;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_tail", tail_idx, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_redirect", redirect_en, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_flush", flush_signal, 0);
        rst_in = 1'b0;

        // Fill without CDB, then a 9th dispatch while full.
        for (int i = 0; i < 8; i++) begin
            disp(T_REG, 5'(i + 1), 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 32'h0, ids[i]);
            push(5'(i + 1), (i == 2) ? 32'hABCD : 32'h1000 + 32'(i), ids[i]);
            tick();
        end
        idle();
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_tail", tail_idx, 0);
        disp_en = 1'b1; disp_type = T_REG; disp_rd = 5'd31; disp_ready = 1'b1;
        tick();
        idle();
        chk("full_ign_count", count, 8);
        chk("full_ign_tail", tail_idx, 0);

        // Drain by CDB while exercising the lookup bypass.
        q0_idx = 3'd2;
        for (int i = 0; i < 8; i++) begin
            v = (i == 2) ? 32'hABCD : 32'h1000 + 32'(i);
            cdb(ids[i], v);
            q1_idx = ids[i];
            #1;
            chk("q1_ready_byp", q1_ready, 1);
            chk("q1_data_byp", q1_data, v);
            if (i == 1) chk("q0_ready_pre", q0_ready, 0);
            if (i == 2) begin
                chk("q0_ready_byp", q0_ready, 1);
                chk("q0_data_byp", q0_data, 32'hABCD);
            end
            tick();
        end
        idle();
        tick(); tick(); tick();
        chk("drain_count", count, 0);
        chk("drain_full", full, 0);
        chk("drain_sb", sb.size(), 0);

        // CDB to a free slot, then allocate that slot not ready.
        cdb(m_tail, 32'hDEAD);
        tick();
        idle();
        disp(T_REG, 5'd9, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, id_a);
        push(5'd9, 32'h77, id_a);
        tick();
        idle();
        tick(); tick();
        chk("nonbusy_count", count, 1);
        cdb(id_a, 32'h77);
        tick();
        idle();
        tick(); tick();
        chk("nonbusy_drain", count, 0);

        // Ready at allocation must wait one cycle; strobe pulses once.
        disp(T_REG, 5'd7, 1'b0, 1'b1, 32'h300, 32'h0, 32'h33, id_a);
        push(5'd7, 32'h33, id_a);
        tick();
        idle();
        chk("alloc_no_retire", rf_en, 0);
        chk("alloc_count", count, 1);
        tick();
        chk("single_rf_en", rf_en, 2'b01);
        chk("single_count", count, 0);
        tick();
        chk("rf_pulse", rf_en, 0);

        // Dual commit.
        disp(T_REG, 5'd5, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, id_a);
        push(5'd5, 32'h11, id_a);
        tick();
        disp(T_REG, 5'd6, 1'b0, 1'b1, 32'h404, 32'h0, 32'h22, id_b);
        push(5'd6, 32'h22, id_b);
        tick();
        idle();
        cdb(id_a, 32'h11);
        tick();
        idle();
        chk("dual_pre_count", count, 2);
        tick();
        chk("dual_rf_en", rf_en, 2'b11);
        chk("dual_count", count, 0);

        // Mispredicted branch with a ready younger entry behind it.
        disp(T_BR, 5'd0, 1'b1, 1'b0, 32'h80, 32'h100, 32'h0, id_a);
        tick();
        disp(T_REG, 5'd12, 1'b0, 1'b1, 32'h84, 32'h0, 32'h99, id_x);
        tick();
        idle();
        cdb(id_a, 32'h0);
        tick();
        idle();
        tick();
        chk("br_redirect_en", redirect_en, 1);
        chk("br_redirect_pc", redirect_pc, 32'h100);
        chk("br_bp_en", bp_en, 1);
        chk("br_bp_pc", bp_pc, 32'h80);
        chk("br_bp_taken", bp_taken, 0);
        chk("br_flush", flush_signal, 1);
        disp(T_REG, 5'd13, 1'b0, 1'b1, 32'h88, 32'h0, 32'h55, id_x);
        tick();
        idle();
        m_tail = '0;
        chk("flush_count", count, 0);
        chk("flush_tail", tail_idx, 0);
        chk("flush_pulse", flush_signal, 0);
        chk("flush_redirect_off", redirect_en, 0);

        // Correctly predicted branch: training only.
        disp(T_BR, 5'd0, 1'b0, 1'b1, 32'h90, 32'h200, 32'h0, id_a);
        tick();
        idle();
        tick();
        chk("brok_bp_en", bp_en, 1);
        chk("brok_bp_pc", bp_pc, 32'h90);
        chk("brok_redirect", redirect_en, 0);
        chk("brok_flush", flush_signal, 0);
        chk("brok_count", count, 0);

        // JALR.
        disp(T_JALR, 5'd1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, id_a);
        push(5'd1, 32'h44, id_a);
        tick();
        idle();
        cdb(id_a, 32'h205);
        tick();
        idle();
        tick();
        chk("jalr_rf_en", rf_en, 2'b01);
        chk("jalr_redirect_en", redirect_en, 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h204);
        chk("jalr_flush", flush_signal, 1);
        tick();
        m_tail = '0;
        chk("jalr_count", count, 0);

        // Steady occupancy of three across several pointer wraps.
        for (int n = 0; n < 3; n++) begin
            idle();
            disp(T_REG, 5'(n % 31 + 1), 1'b0, 1'b0, 32'h1000 + 32'(4 * n), 32'h0, 32'h0, ids[n]);
            push(5'(n % 31 + 1), 32'h5000 + 32'(n), ids[n]);
            if (n == 2) cdb(ids[0], 32'h5000);
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            disp(T_REG, 5'((j + 3) % 31 + 1), 1'b0, 1'b0, 32'h1000 + 32'(4 * (j + 3)),
                 32'h0, 32'h0, ids[j + 3]);
            push(5'((j + 3) % 31 + 1), 32'h5000 + 32'(j + 3), ids[j + 3]);
            cdb(ids[j + 1], 32'h5000 + 32'(j + 1));
            tick();
            chk("wrap_count", count, 3);
        end
        idle();
        cdb(ids[21], 32'h5000 + 32'd21);
        tick();
        cdb(ids[22], 32'h5000 + 32'd22);
        tick();
        idle();
        tick(); tick(); tick();
        chk("wrap_drain", count, 0);

        // Global enable low holds state.
        id_x = tail_idx;
        rdy_in = 1'b0;
        disp(T_REG, 5'd3, 1'b0, 1'b1, 32'h500, 32'h0, 32'h1, id_a);
        tick();
        idle();
        chk("rdy_hold_count", count, 0);
        chk("rdy_hold_tail", tail_idx, id_x);
        rdy_in = 1'b1;
        tick(); tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
